pc_sequencer: RTL and testbench

- Program-counter stage directly downstream of the branch/jump target holding register.
- Owns the PC register and the delay-slot state machine.
- Each instruction step selects the next PC: either PC+4, or the held target (tgt_addr_1) once the delay-slot instruction has run.
- Drives halt detection (`active`) and the `delay` select seen by the rest of the datapath.

---
 rtl/mips_cpu_pkg.sv | 13 +
 rtl/pc_sequencer.sv | 72 +++++++
 tb/tb_pc_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared CPU constants and the PC sequencer state encoding.
package mips_cpu_pkg;

   localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
   localparam logic [31:0] HALT_ADDR    = 32'h00000000;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      DELAY_SLOT = 2'd1,
      HALTED     = 2'd2
   } pc_state_t;

endpackage

// File: rtl/pc_sequencer.sv
// Program counter and branch delay-slot sequencer.
// Each enabled step advances pc by 4. A control transfer enters the
// delay slot, and the held target loads on the step after that.
// A transfer to HALT_ADDR stops the CPU until reset.
// Optional: `define PC_ALIGN_CHECK_EN adds a sticky addr_error output. With it,
// a misaligned target loads and then halts the CPU.
module pc_sequencer
   import mips_cpu_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = mips_cpu_pkg::RESET_VECTOR,
   parameter logic [31:0] HALT_ADDR    = mips_cpu_pkg::HALT_ADDR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clk_enable,
   input  logic        ctrl_xfer,
   input  logic [31:0] tgt_addr_1,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [31:0] pc_plus8,
   output logic        delay,
`ifdef PC_ALIGN_CHECK_EN
   output logic        addr_error,
`endif
   output logic        active,
   output logic [31:0] instr_retired
);

   pc_state_t state;

   // Link and fall-through addresses wrap modulo 2^32.
   assign pc_plus4 = pc + 32'd4;
   assign pc_plus8 = pc + 32'd8;
   assign delay    = (state == DELAY_SLOT);
   assign active   = (state != HALTED);

   // PC, state and retire counter. A halted CPU ignores every input except reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc            <= RESET_VECTOR;
         state         <= RUN;
         instr_retired <= 32'd0;
`ifdef PC_ALIGN_CHECK_EN
         addr_error    <= 1'b0;
`endif
      end else if (clk_enable) begin
         case (state)
            RUN: begin
               pc            <= pc_plus4;
               instr_retired <= instr_retired + 32'd1;
               if (ctrl_xfer) state <= DELAY_SLOT;
            end
            DELAY_SLOT: begin
               // ctrl_xfer is ignored here, so a branch in the delay slot has no effect.
               pc            <= tgt_addr_1;
               instr_retired <= instr_retired + 32'd1;
`ifdef PC_ALIGN_CHECK_EN
               if (tgt_addr_1[1:0] != 2'b00) begin
                  state      <= HALTED;
                  addr_error <= 1'b1;
               end else
`endif
               if (tgt_addr_1 == HALT_ADDR) state <= HALTED;
               else                         state <= RUN;
            end
            HALTED: ;
            default: state <= HALTED;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (either PC_ALIGN_CHECK_EN build).
module tb_pc_sequencer;
   import mips_cpu_pkg::*;

   logic        clk = 1'b0;
   logic        reset, clk_enable, ctrl_xfer;
   logic [31:0] tgt_addr_1;
   logic [31:0] pc, pc_plus4, pc_plus8, instr_retired;
   logic        delay, active;
`ifdef PC_ALIGN_CHECK_EN
   logic        addr_error;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pc_sequencer dut (
      .clk(clk), .reset(reset), .clk_enable(clk_enable), .ctrl_xfer(ctrl_xfer),
      .tgt_addr_1(tgt_addr_1), .pc(pc), .pc_plus4(pc_plus4), .pc_plus8(pc_plus8),
      .delay(delay),
`ifdef PC_ALIGN_CHECK_EN
      .addr_error(addr_error),
`endif
      .active(active), .instr_retired(instr_retired)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Apply inputs, take one clock edge, and settle before sampling.
   task automatic step(input logic r, input logic en, input logic x, input logic [31:0] t);
      reset = r; clk_enable = en; ctrl_xfer = x; tgt_addr_1 = t;
      @(posedge clk); #1;
   endtask

   initial begin
      reset = 1'b1; clk_enable = 1'b0; ctrl_xfer = 1'b0; tgt_addr_1 = 32'h0;

      // Reset state.
      step(1, 0, 0, 32'h0);
      chk("rst_pc", pc, 32'hBFC00000);
      chk("rst_p4", pc_plus4, 32'hBFC00004);
      chk("rst_p8", pc_plus8, 32'hBFC00008);
      chk("rst_delay", {31'd0, delay}, 32'd0);
      chk("rst_active", {31'd0, active}, 32'd1);
      chk("rst_ret", instr_retired, 32'd0);
      chk("rst_state", {30'd0, dut.state}, {30'd0, RUN});
`ifdef PC_ALIGN_CHECK_EN
      chk("rst_aerr", {31'd0, addr_error}, 32'd0);
`endif

      // Sequential steps.
      step(0, 1, 0, 32'h0); chk("seq1_pc", pc, 32'hBFC00004);
      step(0, 1, 0, 32'h0); chk("seq2_pc", pc, 32'hBFC00008);
      step(0, 1, 0, 32'h0); chk("seq3_pc", pc, 32'hBFC0000C);
      chk("seq3_ret", instr_retired, 32'd3);
      chk("seq3_delay", {31'd0, delay}, 32'd0);
      step(0, 1, 0, 32'h0); chk("seq4_pc", pc, 32'hBFC00010);

      // Branch with delay slot.
      step(0, 1, 1, 32'hBFC00100);
      chk("br_ds_pc", pc, 32'hBFC00014);
      chk("br_ds_delay", {31'd0, delay}, 32'd1);
      chk("br_ds_ret", instr_retired, 32'd5);
      step(0, 1, 0, 32'hBFC00100);
      chk("br_tgt_pc", pc, 32'hBFC00100);
      chk("br_tgt_delay", {31'd0, delay}, 32'd0);
      chk("br_tgt_ret", instr_retired, 32'd6);

      // Branch with stall cycles inside the delay slot; ctrl_xfer in the slot is ignored.
      step(0, 1, 1, 32'hBFC00200);
      chk("st_ds_pc", pc, 32'hBFC00104);
      step(0, 0, 0, 32'hBFC00200);
      step(0, 0, 1, 32'hBFC00200);
      chk("st_hold_pc", pc, 32'hBFC00104);
      chk("st_hold_delay", {31'd0, delay}, 32'd1);
      chk("st_hold_ret", instr_retired, 32'd7);
      step(0, 1, 1, 32'hBFC00200);
      chk("st_tgt_pc", pc, 32'hBFC00200);
      chk("st_tgt_delay", {31'd0, delay}, 32'd0);
      chk("st_tgt_state", {30'd0, dut.state}, {30'd0, RUN});
      chk("st_tgt_ret", instr_retired, 32'd8);

      // Misaligned target.
      step(0, 1, 1, 32'hBFC00302);
      chk("mis_ds_pc", pc, 32'hBFC00204);
      step(0, 1, 0, 32'hBFC00302);
      chk("mis_pc", pc, 32'hBFC00302);
`ifdef PC_ALIGN_CHECK_EN
      chk("mis_aerr", {31'd0, addr_error}, 32'd1);
      chk("mis_active", {31'd0, active}, 32'd0);
      step(0, 1, 0, 32'h0);
      chk("mis_hold_pc", pc, 32'hBFC00302);
      chk("mis_sticky", {31'd0, addr_error}, 32'd1);
`else
      chk("mis_active", {31'd0, active}, 32'd1);
      step(0, 1, 0, 32'h0);
      chk("mis_next_pc", pc, 32'hBFC00306);
`endif

      // Reset during the delay slot drops the pending target.
      step(1, 0, 0, 32'h0);
`ifdef PC_ALIGN_CHECK_EN
      chk("rst2_aerr", {31'd0, addr_error}, 32'd0);
`endif
      step(0, 1, 1, 32'hBFC00400);
      chk("rds_pc", pc, 32'hBFC00004);
      chk("rds_delay", {31'd0, delay}, 32'd1);
      step(1, 1, 0, 32'hBFC00400);
      chk("rds_rst_pc", pc, 32'hBFC00000);
      chk("rds_rst_delay", {31'd0, delay}, 32'd0);
      chk("rds_rst_ret", instr_retired, 32'd0);
      step(0, 1, 0, 32'hBFC00400);
      chk("rds_next_pc", pc, 32'hBFC00004);

      // Transfer to HALT_ADDR.
      step(0, 1, 1, 32'h0);
      chk("h_ds_pc", pc, 32'hBFC00008);
      step(0, 1, 0, 32'h0);
      chk("h_pc", pc, 32'h0);
      chk("h_active", {31'd0, active}, 32'd0);
      chk("h_ret", instr_retired, 32'd3);
      chk("h_state", {30'd0, dut.state}, {30'd0, HALTED});
      step(0, 1, 1, 32'hBFC00500);
      step(0, 1, 0, 32'hBFC00500);
      step(0, 1, 1, 32'hBFC00500);
      chk("h_hold_pc", pc, 32'h0);
      chk("h_hold_ret", instr_retired, 32'd3);
      chk("h_hold_active", {31'd0, active}, 32'd0);
      step(1, 0, 0, 32'h0);
      chk("h_rst_pc", pc, 32'hBFC00000);
      chk("h_rst_active", {31'd0, active}, 32'd1);

      // Wrap past the top of the address space: fall-through to 0 does not halt.
      step(0, 1, 1, 32'hFFFFFFF8);
      step(0, 1, 0, 32'hFFFFFFF8);
      chk("w_pc", pc, 32'hFFFFFFF8);
      chk("w_p4", pc_plus4, 32'hFFFFFFFC);
      chk("w_p8", pc_plus8, 32'h0);
      step(0, 1, 0, 32'h0);
      chk("w_pc2", pc, 32'hFFFFFFFC);
      chk("w_p4_2", pc_plus4, 32'h0);
      step(0, 1, 0, 32'h0);
      chk("w_pc0", pc, 32'h0);
      chk("w_active", {31'd0, active}, 32'd1);
      chk("w_state", {30'd0, dut.state}, {30'd0, RUN});
      step(0, 1, 0, 32'h0);
      chk("w_pc4", pc, 32'h4);
      chk("w_ret", instr_retired, 32'd5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
